// File: rtl/hazard_pkg.sv
// Shared constants for the forwarding / hazard unit: register index width,
// the register-file forwarding select and the result-latency encodings.
package hazard_pkg;

    localparam int REG_AW     = 5;
    localparam int FWD_SEL_RF = 0;

    localparam logic [1:0] LAT_ALU  = 2'd0;
    localparam logic [1:0] LAT_LOAD = 2'd1;
    localparam logic [1:0] LAT_MUL  = 2'd2;

endpackage

// File: rtl/fwd_lookup.sv
// Youngest-match search of one source register against the shadow pipeline.
// Stage 1 sits at index 0, so the first hit while scanning upward is the youngest.
module fwd_lookup #(
    parameter int REG_AW    = 5,
    parameter int FWD_DEPTH = 3,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic [REG_AW-1:0]           src,
    input  logic                        used,
    input  logic [FWD_DEPTH-1:0]        v,
    input  logic [FWD_DEPTH*REG_AW-1:0] rd,
    input  logic [FWD_DEPTH-1:0]        ready,
    output logic [SEL_W-1:0]            sel,
    output logic                        stall_req
);
    import hazard_pkg::*;

    logic              lookup_en_s;
    logic              hit_s;
    logic [SEL_W-1:0]  sel_s;
    logic              stall_s;

    assign lookup_en_s = used && (src != {REG_AW{1'b0}});

    // Youngest matching entry decides; an unready youngest match hides older ready ones.
    always_comb begin
        hit_s   = 1'b0;
        sel_s   = SEL_W'(FWD_SEL_RF);
        stall_s = 1'b0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (!hit_s && lookup_en_s && v[k] && (rd[k*REG_AW +: REG_AW] == src)) begin
                hit_s = 1'b1;
                if (ready[k]) begin
                    sel_s   = SEL_W'(k + 1);
                    stall_s = 1'b0;
                end else begin
                    sel_s   = SEL_W'(FWD_SEL_RF);
                    stall_s = 1'b1;
                end
            end else begin
                hit_s = hit_s;
            end
        end
    end

    assign sel       = sel_s;
    assign stall_req = stall_s;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use/latency stall generation beside decode.
// Tracks in-flight register writes in a FWD_DEPTH-stage shadow pipeline.
module fwd_hazard_unit #(
    parameter int          REG_AW        = hazard_pkg::REG_AW,
    parameter int          NUM_SRC       = 2,
    parameter int          FWD_DEPTH     = 3,
    parameter int          SEL_W         = $clog2(FWD_DEPTH + 1),
    parameter int          LAT_W         = 2,
    parameter logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic                      id_regwrite,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic [LAT_W-1:0]          id_lat,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      stall,
    output logic [31:0]               stall_cycles
);
    import hazard_pkg::*;

    logic [FWD_DEPTH-1:0]        v_r;
    logic [FWD_DEPTH*REG_AW-1:0] rd_r;
    logic [FWD_DEPTH*LAT_W-1:0]  cnt_r;
    logic [31:0]                 stall_cycles_r;

    logic [FWD_DEPTH-1:0]        ready_s;
    logic [NUM_SRC-1:0]          src_stall_s;
    logic                        admit_s;
    logic                        stall_s;
    logic [LAT_W-1:0]            lat_cap_s;

    function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] c);
        if (c == {LAT_W{1'b0}}) begin
            return {LAT_W{1'b0}};
        end else begin
            return c - {{(LAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign admit_s = id_valid && id_regwrite && (id_rd != {REG_AW{1'b0}});

    // Latency beyond the last stage cannot be waited out in the pipeline, so clamp it.
    always_comb begin
        if (int'(id_lat) > FWD_DEPTH - 1) begin
            lat_cap_s = LAT_W'(FWD_DEPTH - 1);
        end else begin
            lat_cap_s = id_lat;
        end
    end

    // Per-stage readiness: the result is forwardable once the counter drains.
    always_comb begin
        ready_s = {FWD_DEPTH{1'b0}};
        for (int k = 0; k < FWD_DEPTH; k++) begin
            ready_s[k] = (cnt_r[k*LAT_W +: LAT_W] == {LAT_W{1'b0}});
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_lookup #(
            .REG_AW    (REG_AW),
            .FWD_DEPTH (FWD_DEPTH),
            .SEL_W     (SEL_W)
        ) u_lookup (
            .src       (id_src[i*REG_AW +: REG_AW]),
            .used      (id_src_used[i]),
            .v         (v_r),
            .rd        (rd_r),
            .ready     (ready_s),
            .sel       (fwd_sel[i*SEL_W +: SEL_W]),
            .stall_req (src_stall_s[i])
        );
    end

    assign stall_s = id_valid && (|src_stall_s);
    assign stall   = stall_s;

    // Shadow pipeline advance; a stalled decode injects a bubble into stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r   <= {FWD_DEPTH{1'b0}};
            rd_r  <= {(FWD_DEPTH*REG_AW){1'b0}};
            cnt_r <= {(FWD_DEPTH*LAT_W){1'b0}};
        end else if (flush) begin
            v_r   <= {FWD_DEPTH{1'b0}};
            cnt_r <= {(FWD_DEPTH*LAT_W){1'b0}};
        end else begin
            for (int k = FWD_DEPTH - 1; k > 0; k--) begin
                v_r[k]                    <= v_r[k-1];
                rd_r[k*REG_AW +: REG_AW]  <= rd_r[(k-1)*REG_AW +: REG_AW];
                cnt_r[k*LAT_W +: LAT_W]   <= sat_dec(cnt_r[(k-1)*LAT_W +: LAT_W]);
            end
            v_r[0]             <= admit_s && !stall_s;
            rd_r[0 +: REG_AW]  <= id_rd;
            cnt_r[0 +: LAT_W]  <= stall_s ? LAT_W'(LAT_ALU) : lat_cap_s;
        end
    end

    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= 32'd0;
        end else if (stall_s && (stall_cycles_r != STALL_CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + 32'd1;
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with a per-cycle behavioural model.
module tb_fwd_hazard_unit;
    localparam int          NS   = 2;
    localparam int          D    = 3;
    localparam int          SW   = 2;
    localparam int          LW   = 2;
    localparam int          AW   = 5;
    localparam logic [31:0] CMAX = 32'd40;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              id_valid = 1'b0;
    logic              id_regwrite = 1'b0;
    logic [AW-1:0]     id_rd = '0;
    logic [LW-1:0]     id_lat = '0;
    logic [NS*AW-1:0]  id_src = '0;
    logic [NS-1:0]     id_src_used = '0;
    logic [NS*SW-1:0]  fwd_sel;
    logic              stall;
    logic [31:0]       stall_cycles;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit v;
        int rd;
        int lat;
    } ent_t;

    ent_t        m_pipe[$];
    int unsigned m_cnt = 0;

    fwd_hazard_unit #(
        .REG_AW        (AW),
        .NUM_SRC       (NS),
        .FWD_DEPTH     (D),
        .SEL_W         (SW),
        .LAT_W         (LW),
        .STALL_CNT_MAX (CMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_regwrite  (id_regwrite),
        .id_rd        (id_rd),
        .id_lat       (id_lat),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .fwd_sel      (fwd_sel),
        .stall        (stall),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        ent_t e;
        e.v = 1'b0; e.rd = 0; e.lat = 0;
        m_pipe.delete();
        for (int k = 0; k < D; k++) m_pipe.push_back(e);
    endtask

    // Entry at stage k was issued k-1 moves ago, so it still needs lat-(k-1) cycles.
    function automatic void model_eval(output logic [NS*SW-1:0] sel, output logic stl);
        sel = '0;
        stl = 1'b0;
        for (int i = 0; i < NS; i++) begin
            int s;
            s = int'(id_src[i*AW +: AW]);
            if (id_src_used[i] && s != 0) begin
                for (int k = 1; k <= D; k++) begin
                    if (m_pipe[k-1].v && m_pipe[k-1].rd == s) begin
                        if (m_pipe[k-1].lat - (k - 1) <= 0) sel[i*SW +: SW] = SW'(k);
                        else stl = 1'b1;
                        break;
                    end
                end
            end
        end
        stl = stl & id_valid;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [NS*SW-1:0] es;
        logic             est;
        ent_t             e;
        if (!rst_n) begin
            model_reset();
            m_cnt <= 0;
        end else begin
            model_eval(es, est);
            if (est && m_cnt != CMAX) m_cnt <= m_cnt + 1;
            if (flush) begin
                model_reset();
            end else begin
                e.v   = id_valid && id_regwrite && (id_rd != 0) && !est;
                e.rd  = int'(id_rd);
                e.lat = (int'(id_lat) > D - 1) ? D - 1 : int'(id_lat);
                void'(m_pipe.pop_back());
                m_pipe.push_front(e);
            end
        end
    end

    always @(negedge clk) begin
        logic [NS*SW-1:0] es;
        logic             est;
        if (chk_en) begin
            model_eval(es, est);
            chk("model_fwd_sel", 32'(fwd_sel), 32'(es));
            chk("model_stall", 32'(stall), 32'(est));
            chk("model_stall_cycles", stall_cycles, m_cnt);
        end
    end

    task automatic issue(input logic v, input logic rw, input int rd, input int lat,
                         input int s0, input int s1, input logic [1:0] used,
                         input logic fl = 1'b0);
        @(posedge clk); #1;
        id_valid    = v;
        id_regwrite = rw;
        id_rd       = AW'(rd);
        id_lat      = LW'(lat);
        id_src      = {AW'(s1), AW'(s0)};
        id_src_used = used;
        flush       = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 1'b0, 0, 0, 0, 0, 2'b00);
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        chk_en = 1'b1;

        idle(1);
        #1 chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_fwd_sel", 32'(fwd_sel), 32'd0);
        chk("reset_count", stall_cycles, 32'd0);

        // ALU-ALU chain
        issue(1'b1, 1'b1, 3, 0, 1, 2, 2'b11);
        #1 chk("alu_first", 32'(fwd_sel), 32'd0);
        issue(1'b1, 1'b1, 4, 0, 3, 1, 2'b11);
        #1 chk("alu_fwd_stage1", 32'(fwd_sel), 32'b0001);
        chk("alu_no_stall", 32'(stall), 32'd0);
        issue(1'b1, 1'b1, 6, 0, 2, 3, 2'b11);
        #1 chk("alu_fwd_stage2", 32'(fwd_sel), 32'b1000);
        idle(3);

        // load-use
        issue(1'b1, 1'b1, 5, 1, 0, 0, 2'b00);
        issue(1'b1, 1'b1, 8, 0, 5, 0, 2'b01);
        #1 chk("lu_stall", 32'(stall), 32'd1);
        issue(1'b1, 1'b1, 8, 0, 5, 0, 2'b01);
        #1 chk("lu_release", 32'(stall), 32'd0);
        chk("lu_fwd_stage2", 32'(fwd_sel), 32'b0010);
        chk("lu_count", stall_cycles, 32'd1);
        idle(3);

        // youngest match wins
        issue(1'b1, 1'b1, 7, 0, 0, 0, 2'b00);
        issue(1'b1, 1'b1, 10, 0, 0, 0, 2'b00);
        issue(1'b1, 1'b1, 7, 0, 0, 0, 2'b00);
        issue(1'b1, 1'b0, 0, 0, 1, 7, 2'b11);
        #1 chk("young_ready", 32'(fwd_sel), 32'b0100);
        idle(3);
        issue(1'b1, 1'b1, 7, 0, 0, 0, 2'b00);
        issue(1'b1, 1'b1, 11, 0, 0, 0, 2'b00);
        issue(1'b1, 1'b1, 7, 2, 0, 0, 2'b00);
        issue(1'b1, 1'b0, 0, 0, 7, 0, 2'b01);
        #1 chk("young_unready_stall", 32'(stall), 32'd1);
        issue(1'b1, 1'b0, 0, 0, 7, 0, 2'b01);
        #1 chk("mul_stall2", 32'(stall), 32'd1);
        issue(1'b1, 1'b0, 0, 0, 7, 0, 2'b01);
        #1 chk("mul_fwd_stage3", 32'(fwd_sel), 32'b0011);
        chk("mul_count", stall_cycles, 32'd3);
        idle(3);

        // zero register and unused source
        issue(1'b1, 1'b1, 0, 0, 0, 0, 2'b00);
        issue(1'b1, 1'b0, 0, 0, 0, 0, 2'b01);
        #1 chk("r0_fwd", 32'(fwd_sel), 32'd0);
        chk("r0_stall", 32'(stall), 32'd0);
        issue(1'b1, 1'b1, 12, 1, 0, 0, 2'b00);
        issue(1'b1, 1'b0, 0, 0, 12, 1, 2'b10);
        #1 chk("unused_stall", 32'(stall), 32'd0);
        chk("unused_fwd", 32'(fwd_sel), 32'd0);
        idle(3);

        // flush
        issue(1'b1, 1'b1, 9, 2, 0, 0, 2'b00);
        issue(1'b1, 1'b0, 0, 0, 9, 0, 2'b01, 1'b1);
        #1 chk("flush_cycle_stall", 32'(stall), 32'd1);
        issue(1'b1, 1'b0, 0, 0, 9, 0, 2'b01);
        #1 chk("post_flush_stall", 32'(stall), 32'd0);
        chk("post_flush_fwd", 32'(fwd_sel), 32'd0);
        chk("flush_count", stall_cycles, 32'd4);
        idle(3);

        // asynchronous reset while stalling
        issue(1'b1, 1'b1, 13, 2, 0, 0, 2'b00);
        issue(1'b1, 1'b0, 0, 0, 13, 0, 2'b01);
        #1 chk("pre_reset_stall", 32'(stall), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("async_reset_stall", 32'(stall), 32'd0);
        chk("async_reset_count", stall_cycles, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        idle(2);

        // saturation with a self-dependent mul held in decode
        repeat (70) issue(1'b1, 1'b1, 14, 2, 14, 0, 2'b01);
        #1 chk("sat_count", stall_cycles, CMAX);
        repeat (6) issue(1'b1, 1'b1, 14, 2, 14, 0, 2'b01);
        #1 chk("sat_hold", stall_cycles, CMAX);
        idle(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
